seg_merge_acc: RTL and testbench
================================

SEG_MERGE_ACC -- requirements
Module: seg_merge_acc

Interface
REQ-001 Parameter LANES, default 3: segment lanes per beat; lane 0 is earliest in packet order, lane LANES-1 latest.
REQ-002 Parameter CRC_W, default 32: partial-CRC width per lane.
REQ-003 Parameter PN_W, default 4: packet-number width.
REQ-004 Parameter ZN_W, default 12: zero-count width.
REQ-005 Parameter SC_W, default 8: segment-count width.
REQ-006 Ports:
  clk  in  1  sole clock
  rst  in  1  synchronous reset, active-high
  sop_in  in  LANES  per-lane start of packet
  eop_in  in  LANES  per-lane end of packet
  dval_in  in  LANES  per-lane segment valid
  packet_num_in  in  LANES*PN_W  per-lane packet number, lane i at [i*PN_W +: PN_W]
  zero_num_in  in  LANES*ZN_W  per-lane zero count, same packing
  dout_in  in  LANES*CRC_W  per-lane partial CRC, same packing
  merge_dval_out  out  1  one-cycle pulse, merged packet result valid
  merge_packet_num_out  out  PN_W  packet number of merged result
  merge_zero_num_out  out  ZN_W  zero count of merged result
  merge_dout_out  out  CRC_W  XOR of all segment CRCs of the packet
  merge_seg_cnt_out  out  SC_W  segments merged into the packet
  merge_err_out  out  1  one-cycle pulse, protocol error seen

Function
REQ-007 A lane with dval_in=0 SHALL be ignored, including its sop_in and eop_in.
REQ-008 Stage 1 SHALL register all inputs; stage 2 SHALL compute and register outputs and the accumulator state; latency = 2 cycles from the eop beat to merge_dval_out.
REQ-009 State: open flag, CRC_W accumulator, SC_W segment counter; full throughput, back-to-back beats with no bubbles.
REQ-010 Legal beat: at most one valid sop lane s and at most one valid eop lane e.
REQ-011 No s, no e: if open, acc ^= all valid lanes and cnt += valid-lane count; if closed, the beat is discarded.
REQ-012 e only, open: output = acc ^ lanes 0..e; cnt_out = cnt + valid lanes 0..e; close; lanes above e discarded.
REQ-013 s only: acc = XOR of lanes s..LANES-1; cnt = valid lanes s..LANES-1; open; lanes below s are first XORed into the old packet if open (open packet still open, then restarted -> error per REQ-016).
REQ-014 e < s: close as REQ-012 for lanes 0..e, then open as REQ-013 for lanes s..LANES-1, both in the same cycle.
REQ-015 s <= e: output = XOR of lanes s..e, cnt_out = valid lanes s..e; state closed afterwards; s == e is a single-segment packet.
REQ-016 Errors, each a one-cycle merge_err_out pulse in the stage-2 output cycle: sop while open and not closed earlier in the beat (old packet dropped, no output); eop while closed with no sop at or below e (segments dropped); more than one valid sop or eop in a beat (whole beat dropped, state unchanged).
REQ-017 merge_packet_num_out and merge_zero_num_out SHALL come from lane e.
REQ-018 The segment counter SHALL saturate at 2^SC_W-1.
REQ-019 Outputs SHALL hold their last value between pulses; merge_dval_out and merge_err_out are 0 except during pulses.

Reset
REQ-020 On rst=1 at a clk edge: all outputs 0, open=0, accumulator 0, counter 0, stage-1 dval/sop/eop registers 0.
REQ-021 Reset mid-packet SHALL discard the open packet with no output and no error pulse; the first beat after reset is evaluated from the closed state.

Configuration
REQ-022 Macro MERGE_ERR_CHK_EN defined: REQ-016 detection and merge_err_out active.
REQ-023 Macro MERGE_ERR_CHK_EN undefined: merge_err_out tied to 0; an illegal beat uses the lowest valid eop and the highest valid sop; sop while open restarts silently; eop while closed is discarded silently.

Verification (LANES=3, CRC_W=32)
REQ-024 Beat 1: sop/dval on lane 0, dout=11111111/22222222/44444444, eop on lane 2, pn=5, zn=0x00C -> 2 cycles later: dval pulse, dout=77777777, pn=5, zn=0x00C, cnt=3.
REQ-025 Beat 1: sop on lane 1 (lanes 1-2 = 0000000F, 000000F0); beat 2: all lanes = 00000F00, eop on lane 0 -> one pulse, dout=00000FFF, cnt=3.
REQ-026 Single beat, eop on lane 0 closing an open acc=A5A5A5A5 with lane 0 = 0000005A, sop on lane 2 with lane 2 = 12345678, eop next beat on lane 0 = 0 -> pulses dout=A5A5A5FF then 12345678.
REQ-027 Eop on lane 1 with no open packet -> no dval pulse; merge_err_out=1 for one cycle; with the macro undefined, err stays 0.
REQ-028 Open packet, rst asserted one cycle, then a beat with eop only -> no dval pulse, err pulse (macro defined), all outputs 0 during reset.

Source files
------------

// File: rtl/seg_merge_acc.sv
// Two-stage merge of per-lane partial CRC segments into per-packet results.
// Define MERGE_ERR_CHK_EN to enable protocol-error detection on merge_err_out.
module seg_merge_acc #(
  parameter int LANES = 3,
  parameter int CRC_W = 32,
  parameter int PN_W  = 4,
  parameter int ZN_W  = 12,
  parameter int SC_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       sop_in,
  input  logic [LANES-1:0]       eop_in,
  input  logic [LANES-1:0]       dval_in,
  input  logic [LANES*PN_W-1:0]  packet_num_in,
  input  logic [LANES*ZN_W-1:0]  zero_num_in,
  input  logic [LANES*CRC_W-1:0] dout_in,
  output logic                   merge_dval_out,
  output logic [PN_W-1:0]        merge_packet_num_out,
  output logic [ZN_W-1:0]        merge_zero_num_out,
  output logic [CRC_W-1:0]       merge_dout_out,
  output logic [SC_W-1:0]        merge_seg_cnt_out,
  output logic                   merge_err_out
);

`ifdef MERGE_ERR_CHK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  logic [LANES-1:0]       s1_sop, s1_eop, s1_dval;
  logic [LANES*PN_W-1:0]  s1_pn;
  logic [LANES*ZN_W-1:0]  s1_zn;
  logic [LANES*CRC_W-1:0] s1_dout;

  logic             open_q, nxt_open;
  logic [CRC_W-1:0] acc_q, nxt_acc;
  logic [SC_W-1:0]  cnt_q, nxt_cnt;

  logic             out_vld, err_raw;
  logic [CRC_W-1:0] out_crc;
  logic [SC_W-1:0]  out_cnt;
  logic [PN_W-1:0]  out_pn;
  logic [ZN_W-1:0]  out_zn;

  logic [LANES-1:0] vs, ve;
  logic             has_s, has_e, multi;
  int               s_idx, e_idx, n_s, n_e;
  logic [CRC_W-1:0] x_all, x_lo, x_hi, x_mid;
  logic [SC_W-1:0]  c_all, c_lo, c_hi, c_mid;

  function automatic logic [SC_W-1:0] sat_add(input logic [SC_W-1:0] a,
                                               input logic [SC_W-1:0] b);
    logic [SC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SC_W] ? {SC_W{1'b1}} : sum[SC_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sop  <= '0;
      s1_eop  <= '0;
      s1_dval <= '0;
      s1_pn   <= '0;
      s1_zn   <= '0;
      s1_dout <= '0;
    end else begin
      s1_sop  <= sop_in;
      s1_eop  <= eop_in;
      s1_dval <= dval_in;
      s1_pn   <= packet_num_in;
      s1_zn   <= zero_num_in;
      s1_dout <= dout_in;
    end
  end

  always_comb begin
    vs    = s1_sop & s1_dval;
    ve    = s1_eop & s1_dval;
    has_s = 1'b0;
    has_e = 1'b0;
    s_idx = 0;
    e_idx = 0;
    n_s   = 0;
    n_e   = 0;
    // Ascending scan: the highest sop and the lowest eop win.
    for (int i = 0; i < LANES; i++) begin
      if (vs[i]) begin
        has_s = 1'b1;
        s_idx = i;
        n_s   = n_s + 1;
      end
      if (ve[i]) begin
        if (!has_e) e_idx = i;
        has_e = 1'b1;
        n_e   = n_e + 1;
      end
    end
    multi = ERR_CHK && ((n_s > 1) || (n_e > 1));

    x_all = '0; x_lo = '0; x_hi = '0; x_mid = '0;
    c_all = '0; c_lo = '0; c_hi = '0; c_mid = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_dval[i]) begin
        x_all = x_all ^ s1_dout[i*CRC_W +: CRC_W];
        c_all = c_all + SC_W'(1);
        if (i <= e_idx) begin
          x_lo = x_lo ^ s1_dout[i*CRC_W +: CRC_W];
          c_lo = c_lo + SC_W'(1);
        end
        if (i >= s_idx) begin
          x_hi = x_hi ^ s1_dout[i*CRC_W +: CRC_W];
          c_hi = c_hi + SC_W'(1);
        end
        if (i >= s_idx && i <= e_idx) begin
          x_mid = x_mid ^ s1_dout[i*CRC_W +: CRC_W];
          c_mid = c_mid + SC_W'(1);
        end
      end
    end

    nxt_open = open_q;
    nxt_acc  = acc_q;
    nxt_cnt  = cnt_q;
    out_vld  = 1'b0;
    err_raw  = 1'b0;
    out_crc  = '0;
    out_cnt  = '0;
    out_pn   = s1_pn[e_idx*PN_W +: PN_W];
    out_zn   = s1_zn[e_idx*ZN_W +: ZN_W];

    if (multi) begin
      err_raw = 1'b1;
    end else if (!has_s && !has_e) begin
      if (open_q) begin
        nxt_acc = acc_q ^ x_all;
        nxt_cnt = sat_add(cnt_q, c_all);
      end
    end else if (has_e && (!has_s || e_idx < s_idx)) begin
      // Close the running packet on lanes 0..e, then optionally reopen at s.
      if (open_q) begin
        out_vld = 1'b1;
        out_crc = acc_q ^ x_lo;
        out_cnt = sat_add(cnt_q, c_lo);
      end else begin
        err_raw = 1'b1;
      end
      nxt_open = 1'b0;
      nxt_acc  = '0;
      nxt_cnt  = '0;
      if (has_s) begin
        nxt_open = 1'b1;
        nxt_acc  = x_hi;
        nxt_cnt  = c_hi;
      end
    end else if (has_s && !has_e) begin
      err_raw  = open_q;
      nxt_open = 1'b1;
      nxt_acc  = x_hi;
      nxt_cnt  = c_hi;
    end else begin
      // s <= e: a complete packet inside this beat.
      err_raw  = open_q;
      out_vld  = 1'b1;
      out_crc  = x_mid;
      out_cnt  = c_mid;
      nxt_open = 1'b0;
      nxt_acc  = '0;
      nxt_cnt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q               <= 1'b0;
      acc_q                <= '0;
      cnt_q                <= '0;
      merge_dval_out       <= 1'b0;
      merge_err_out        <= 1'b0;
      merge_packet_num_out <= '0;
      merge_zero_num_out   <= '0;
      merge_dout_out       <= '0;
      merge_seg_cnt_out    <= '0;
    end else begin
      open_q         <= nxt_open;
      acc_q          <= nxt_acc;
      cnt_q          <= nxt_cnt;
      merge_dval_out <= out_vld;
      merge_err_out  <= ERR_CHK && err_raw;
      if (out_vld) begin
        merge_packet_num_out <= out_pn;
        merge_zero_num_out   <= out_zn;
        merge_dout_out       <= out_crc;
        merge_seg_cnt_out    <= out_cnt;
      end
    end
  end

endmodule

// File: tb/tb_seg_merge_acc.sv
// Scoreboard bench for seg_merge_acc: directed beats push expected merged results,
// a monitor compares every output cycle (pulse, hold, reset) against the queue.
module tb_seg_merge_acc;
  localparam int EW = 4 + 12 + 32 + 8 + 32;

`ifdef MERGE_ERR_CHK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sop_in = '0, eop_in = '0, dval_in = '0;
  logic [11:0] packet_num_in = '0;
  logic [35:0] zero_num_in = '0;
  logic [95:0] dout_in = '0;
  logic        merge_dval_out, merge_err_out;
  logic [3:0]  merge_packet_num_out;
  logic [11:0] merge_zero_num_out;
  logic [31:0] merge_dout_out;
  logic [7:0]  merge_seg_cnt_out;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int err_seen = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_cyc = '0;
  logic rst_seen = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [55:0] last_out = '0;

  seg_merge_acc dut (
    .clk(clk), .rst(rst),
    .sop_in(sop_in), .eop_in(eop_in), .dval_in(dval_in),
    .packet_num_in(packet_num_in), .zero_num_in(zero_num_in), .dout_in(dout_in),
    .merge_dval_out(merge_dval_out), .merge_packet_num_out(merge_packet_num_out),
    .merge_zero_num_out(merge_zero_num_out), .merge_dout_out(merge_dout_out),
    .merge_seg_cnt_out(merge_seg_cnt_out), .merge_err_out(merge_err_out)
  );

  // Clock and reset-observation block
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen <= rst;
  end

  // Driver tasks
  task automatic beat(input logic [2:0] s, input logic [2:0] e, input logic [2:0] v,
                      input logic [95:0] d, input logic [11:0] pn, input logic [35:0] zn);
    @(posedge clk);
    #1;
    sop_in = s; eop_in = e; dval_in = v;
    dout_in = d; packet_num_in = pn; zero_num_in = zn;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(3'b000, 3'b000, 3'b000, '0, '0, '0);
  endtask

  task automatic expect_out(input logic [3:0] pn, input logic [11:0] zn,
                            input logic [31:0] d, input logic [7:0] c);
    exp_q.push_back({pn, zn, d, c, last_cyc + 32'd2});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [55:0] got;
    logic [EW-1:0] e;
    got = {merge_packet_num_out, merge_zero_num_out, merge_dout_out, merge_seg_cnt_out};
    if (rst_seen) begin
      checks++;
      if (got != '0 || merge_dval_out || merge_err_out) begin
        failures++;
        $display("FAIL reset_outputs got=%h dval=%b err=%b required all zero",
                 got, merge_dval_out, merge_err_out);
      end
      last_out = '0;
    end else if (merge_dval_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got=%h cyc=%0d required no pulse", got, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({got, cyc} != e) begin
          failures++;
          $display("FAIL merged_result got pn=%h zn=%h dout=%h cnt=%0d cyc=%0d required pn=%h zn=%h dout=%h cnt=%0d cyc=%0d",
                   merge_packet_num_out, merge_zero_num_out, merge_dout_out, merge_seg_cnt_out, cyc,
                   e[87:84], e[83:72], e[71:40], e[39:32], e[31:0]);
        end
      end
      last_out = got;
    end else begin
      checks++;
      if (got != last_out) begin
        failures++;
        $display("FAIL hold_outputs got=%h required=%h cyc=%0d", got, last_out, cyc);
      end
    end
    if (merge_err_out) err_seen++;
  end

  initial begin
    logic [31:0] x;
    logic [31:0] w;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full packet in one beat, lanes 0..2
    beat(3'b001, 3'b100, 3'b111, {32'h44444444, 32'h22222222, 32'h11111111},
         {4'h5, 4'h2, 4'h1}, {12'h00C, 12'h002, 12'h001});
    expect_out(4'h5, 12'h00C, 32'h77777777, 8'd3);
    idle(2);

    // Packet across two back-to-back beats
    beat(3'b010, 3'b000, 3'b110, {32'h000000F0, 32'h0000000F, 32'h0}, '0, '0);
    beat(3'b000, 3'b001, 3'b111, {32'h00000F00, 32'h00000F00, 32'h00000F00},
         {4'h9, 4'h8, 4'h3}, {12'h0, 12'h0, 12'h123});
    expect_out(4'h3, 12'h123, 32'h00000FFF, 8'd3);
    idle(2);

    // Close on lane 0 and reopen on lane 2 in the same beat; lane 1 discarded
    beat(3'b001, 3'b000, 3'b001, {32'h0, 32'h0, 32'hA5A5A5A5}, '0, '0);
    beat(3'b100, 3'b001, 3'b111, {32'h12345678, 32'hDEADBEEF, 32'h0000005A},
         {4'hC, 4'hB, 4'hA}, {12'h0CC, 12'h0BB, 12'h0AA});
    expect_out(4'hA, 12'h0AA, 32'hA5A5A5FF, 8'd2);
    beat(3'b000, 3'b001, 3'b001, '0, {4'h0, 4'h0, 4'h7}, {12'h0, 12'h0, 12'h077});
    expect_out(4'h7, 12'h077, 32'h12345678, 8'd2);
    idle(2);

    // Eop with no open packet
    beat(3'b000, 3'b010, 3'b010, {32'h0, 32'h55, 32'h0}, '0, '0);
    exp_err += CHK;
    idle(2);

    // Single-segment packet on lane 1
    beat(3'b010, 3'b010, 3'b010, {32'h0, 32'hCAFEF00D, 32'h0},
         {4'h0, 4'hE, 4'h0}, {12'h0, 12'hEEE, 12'h0});
    expect_out(4'hE, 12'hEEE, 32'hCAFEF00D, 8'd1);
    idle(2);

    // Sop while open: old packet dropped, new one continues
    beat(3'b001, 3'b000, 3'b111, {32'h4, 32'h2, 32'h1}, '0, '0);
    beat(3'b010, 3'b000, 3'b010, {32'h0, 32'h10, 32'h0}, '0, '0);
    exp_err += CHK;
    beat(3'b000, 3'b001, 3'b001, {32'h0, 32'h0, 32'h100}, {4'h0, 4'h0, 4'h6}, {12'h0, 12'h0, 12'h066});
    expect_out(4'h6, 12'h066, 32'h00000110, 8'd2);
    idle(2);

    // Two sops in one beat
    beat(3'b011, 3'b000, 3'b011, {32'h0, 32'h2, 32'h1}, '0, '0);
    beat(3'b000, 3'b001, 3'b001, {32'h0, 32'h0, 32'h4}, {4'h0, 4'h0, 4'h2}, {12'h0, 12'h0, 12'h022});
`ifdef MERGE_ERR_CHK_EN
    exp_err += 2;
`else
    expect_out(4'h2, 12'h022, 32'h00000006, 8'd2);
`endif
    idle(2);

    // Valid lanes while closed are discarded
    beat(3'b000, 3'b000, 3'b111, {32'h9, 32'h9, 32'h9}, '0, '0);
    beat(3'b001, 3'b001, 3'b001, {32'h0, 32'h0, 32'h1234}, {4'h0, 4'h0, 4'h1}, {12'h0, 12'h0, 12'h111});
    expect_out(4'h1, 12'h111, 32'h00001234, 8'd1);
    idle(2);

    // Counter saturation across a long back-to-back packet
    x = 32'h0BAD0001;
    beat(3'b100, 3'b000, 3'b100, {x, 32'h0, 32'h0}, '0, '0);
    for (int i = 0; i < 90; i++) begin
      w = 32'h01010101 * (i + 1);
      x = x ^ w ^ (w << 4) ^ (w >> 3);
      beat(3'b000, 3'b000, 3'b111, {w >> 3, w << 4, w}, '0, '0);
    end
    x = x ^ 32'hF0F0F0F0;
    beat(3'b000, 3'b001, 3'b001, {32'h0, 32'h0, 32'hF0F0F0F0}, {4'h0, 4'h0, 4'hF}, {12'h0, 12'h0, 12'hFFF});
    expect_out(4'hF, 12'hFFF, x, 8'd255);
    idle(2);

    // Reset mid-packet, then an orphan eop
    beat(3'b001, 3'b000, 3'b001, {32'h0, 32'h0, 32'h77}, '0, '0);
    idle(2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(3'b000, 3'b100, 3'b100, {32'h88, 32'h0, 32'h0}, '0, '0);
    exp_err += CHK;
    idle(4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got=%0d outstanding required=0", exp_q.size());
    end
    checks++;
    if (err_seen != exp_err) begin
      failures++;
      $display("FAIL err_pulse_count got=%0d required=%0d", err_seen, exp_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
